pet_mood_select: RTL and testbench

//  Virtual-pet state engine upstream of the character-LCD writer. Holds four need

---
 rtl/pet_pkg.sv | 37 +++
 rtl/pet_tick_gen.sv | 41 ++++
 rtl/pet_mood_select.sv | 176 +++++++++++++++++
 tb/tb_pet_mood_select.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pet_pkg.sv
// Shared types and constants for the virtual-pet mood engine.
package pet_pkg;

  typedef enum logic [1:0] {
    AWAKE    = 2'd0,
    SLEEP    = 2'd1,
    CRITICAL = 2'd2
  } pet_state_e;

  localparam logic [1:0] FACE_SAD     = 2'b00;
  localparam logic [1:0] FACE_HAPPY   = 2'b01;
  localparam logic [1:0] FACE_NEUTRAL = 2'b10;

  localparam logic [1:0] ICON_HEALTH = 2'b00;
  localparam logic [1:0] ICON_ENERGY = 2'b01;
  localparam logic [1:0] ICON_FOOD   = 2'b10;
  localparam logic [1:0] ICON_FUN    = 2'b11;

  // Position of each need inside the packed stat vector {fun,energy,food,health}
  localparam int IDX_HEALTH = 0;
  localparam int IDX_FOOD   = 1;
  localparam int IDX_ENERGY = 2;
  localparam int IDX_FUN    = 3;

  // Icon shown at each step of the happy-face rotation: health, food, energy, fun
  function automatic logic [1:0] rot_icon(input logic [1:0] idx);
    logic [1:0] icon;
    unique case (idx)
      2'd0:    icon = ICON_HEALTH;
      2'd1:    icon = ICON_FOOD;
      2'd2:    icon = ICON_ENERGY;
      default: icon = ICON_FUN;
    endcase
    return icon;
  endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// Time base for the pet: a prescaler producing base_tick every TICK_DIV cycles and
// a second counter producing decay_strobe every DECAY_TICKS base ticks.
module pet_tick_gen #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int DECAY_TICKS = 10
) (
  input  logic clk,
  input  logic reset,
  output logic base_tick,
  output logic decay_strobe
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] decay_cnt_q, decay_cnt_d;

  // Pulses are decoded from the terminal count; both counters wrap on their pulse
  always_comb begin
    base_tick    = (presc_q == PW'(TICK_DIV - 1));
    decay_strobe = base_tick && (decay_cnt_q == DW'(DECAY_TICKS - 1));
    presc_d      = base_tick ? '0 : presc_q + PW'(1);
    decay_cnt_d  = decay_cnt_q;
    if (base_tick) begin
      decay_cnt_d = decay_strobe ? '0 : decay_cnt_q + DW'(1);
    end
  end

  // Counter registers, cleared by reset so no stale strobe survives it
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q     <= '0;
      decay_cnt_q <= '0;
    end else begin
      presc_q     <= presc_d;
      decay_cnt_q <= decay_cnt_d;
    end
  end

endmodule

// File: rtl/pet_mood_select.sv
// Virtual-pet state engine: holds the four need levels, decays them, applies player
// actions and produces the registered 4-bit figure code {face, icon} for the LCD writer.
// Optional feature: define PET_ROTATE_EN to rotate the icon on every base tick while
// the face is happy.
module pet_mood_select
  import pet_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int DECAY_TICKS = 10,
  parameter int STAT_MAX    = 10,
  parameter int STEP        = 3,
  parameter int LOW_THR     = 3,
  parameter int HIGH_THR    = 7,
  localparam int SW         = $clog2(STAT_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_feed,
  input  logic          btn_play,
  input  logic          btn_heal,
  input  logic          btn_sleep,
  output logic [3:0]    select_figures,
  output logic          sleeping,
  output logic [4*SW-1:0] stats
);

  localparam logic [SW:0]   STEP_W = (SW+1)'(STEP);
  localparam logic [SW:0]   ONE_W  = (SW+1)'(1);
  localparam logic [SW:0]   MAX_W  = (SW+1)'(STAT_MAX);
  localparam logic [SW-1:0] MAX_S  = SW'(STAT_MAX);
  localparam logic [SW-1:0] STEP_S = SW'(STEP);
  localparam logic [SW-1:0] LOW_S  = SW'(LOW_THR);
  localparam logic [SW-1:0] HIGH_S = SW'(HIGH_THR);

  pet_state_e          state_q, state_d;
  logic [3:0][SW-1:0]  stat_q, stat_d;
  logic [3:0]          fig_q, fig_d;
  logic                base_tick, decay_strobe;
  logic [SW-1:0]       min_v;
  logic [1:0]          icon_low;
  logic                all_high, happy;

  // Add then decrement in one extra bit so action and decay saturate only once
  function automatic logic [SW-1:0] sat_step(input logic [SW-1:0] v,
                                             input logic [SW:0]   inc,
                                             input logic          dec);
    logic [SW:0] t;
    t = {1'b0, v} + inc;
    if (dec) t = (t == '0) ? '0 : t - ONE_W;
    if (t > MAX_W) t = MAX_W;
    return t[SW-1:0];
  endfunction

  pet_tick_gen #(
    .TICK_DIV    (TICK_DIV),
    .DECAY_TICKS (DECAY_TICKS)
  ) u_tick_gen (
    .clk          (clk),
    .reset        (reset),
    .base_tick    (base_tick),
    .decay_strobe (decay_strobe)
  );

  // Next need levels for the current mode, actions and decay strobe
  always_comb begin
    stat_d = stat_q;
    unique case (state_q)
      AWAKE: begin
        stat_d[IDX_HEALTH] = sat_step(stat_q[IDX_HEALTH], btn_heal ? STEP_W : '0, decay_strobe);
        stat_d[IDX_FOOD]   = sat_step(stat_q[IDX_FOOD],   btn_feed ? STEP_W : '0, decay_strobe);
        stat_d[IDX_ENERGY] = sat_step(stat_q[IDX_ENERGY], '0,                     decay_strobe);
        stat_d[IDX_FUN]    = sat_step(stat_q[IDX_FUN],    btn_play ? STEP_W : '0, decay_strobe);
      end
      SLEEP: begin
        stat_d[IDX_HEALTH] = sat_step(stat_q[IDX_HEALTH], btn_heal ? STEP_W : '0, decay_strobe);
        stat_d[IDX_FOOD]   = sat_step(stat_q[IDX_FOOD],   '0,                     decay_strobe);
        stat_d[IDX_ENERGY] = sat_step(stat_q[IDX_ENERGY], decay_strobe ? ONE_W : '0, 1'b0);
        stat_d[IDX_FUN]    = sat_step(stat_q[IDX_FUN],    '0,                     decay_strobe);
      end
      CRITICAL: begin
        if (btn_heal) stat_d[IDX_HEALTH] = STEP_S;
      end
      default: ;
    endcase
  end

  // Mode transitions look at the upcoming levels; empty health always wins
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AWAKE: begin
        if (stat_d[IDX_HEALTH] == '0)      state_d = CRITICAL;
        else if (btn_sleep)                state_d = SLEEP;
      end
      SLEEP: begin
        if (stat_d[IDX_HEALTH] == '0)      state_d = CRITICAL;
        else if (btn_sleep || stat_d[IDX_ENERGY] == MAX_S) state_d = AWAKE;
      end
      CRITICAL: begin
        if (btn_heal)                      state_d = AWAKE;
      end
      default:                             state_d = AWAKE;
    endcase
  end

`ifdef PET_ROTATE_EN
  logic [1:0] rot_q, rot_d;

  // Rotation index advances on base ticks while happy and restarts at health otherwise
  always_comb begin
    if (!happy)         rot_d = 2'd0;
    else if (base_tick) rot_d = rot_q + 2'd1;
    else                rot_d = rot_q;
  end

  // Rotation index register
  always_ff @(posedge clk) begin
    if (!reset) rot_q <= 2'd0;
    else        rot_q <= rot_d;
  end
`else
  logic base_tick_unused;
  assign base_tick_unused = base_tick;
`endif

  // Figure code from the current levels: lowest stat picks the icon, ties favour health
  always_comb begin
    min_v    = stat_q[IDX_HEALTH];
    icon_low = ICON_HEALTH;
    if (stat_q[IDX_FOOD] < min_v) begin
      min_v    = stat_q[IDX_FOOD];
      icon_low = ICON_FOOD;
    end
    if (stat_q[IDX_ENERGY] < min_v) begin
      min_v    = stat_q[IDX_ENERGY];
      icon_low = ICON_ENERGY;
    end
    if (stat_q[IDX_FUN] < min_v) begin
      min_v    = stat_q[IDX_FUN];
      icon_low = ICON_FUN;
    end
    all_high = (stat_q[IDX_HEALTH] >= HIGH_S) && (stat_q[IDX_FOOD] >= HIGH_S) &&
               (stat_q[IDX_ENERGY] >= HIGH_S) && (stat_q[IDX_FUN] >= HIGH_S);
    happy    = (state_q == AWAKE) && all_high && !(min_v < LOW_S);
    unique case (state_q)
      CRITICAL: fig_d = 4'b0000;
      SLEEP:    fig_d = {FACE_NEUTRAL, ICON_ENERGY};
      default: begin
        if (min_v < LOW_S) fig_d = {FACE_SAD, icon_low};
        else if (happy)    fig_d = {FACE_HAPPY, icon_low};
        else               fig_d = {FACE_NEUTRAL, icon_low};
`ifdef PET_ROTATE_EN
        if (happy) fig_d[1:0] = rot_icon(rot_q);
`endif
      end
    endcase
  end

  // State, need levels and the registered figure code
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= AWAKE;
      stat_q  <= {4{MAX_S}};
      fig_q   <= {FACE_HAPPY, ICON_HEALTH};
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      fig_q   <= fig_d;
    end
  end

  assign select_figures = fig_q;
  assign sleeping       = (state_q == SLEEP);
  assign stats          = stat_q;

endmodule

// File: tb/tb_pet_mood_select.sv
// Self-checking bench for pet_mood_select with a fast time base (TICK_DIV=4,
// DECAY_TICKS=2). A behavioural model tracks the pet from the plain rules.
module tb_pet_mood_select;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_feed, btn_play, btn_heal, btn_sleep;
  logic [3:0]  select_figures;
  logic        sleeping;
  logic [15:0] stats;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: needs indexed health, food, energy, fun; mode 0 awake, 1 asleep, 2 critical
  int         st[4];
  int         mode;
  int         edge_cnt;
  int         rot;
  logic [3:0] fig_exp;

  always #5 clk = ~clk;

  pet_mood_select #(
    .TICK_DIV    (4),
    .DECAY_TICKS (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_feed       (btn_feed),
    .btn_play       (btn_play),
    .btn_heal       (btn_heal),
    .btn_sleep      (btn_sleep),
    .select_figures (select_figures),
    .sleeping       (sleeping),
    .stats          (stats)
  );

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int clampStat(input int x);
    return (x < 0) ? 0 : (x > 10) ? 10 : x;
  endfunction

  function automatic logic [15:0] modelStats();
    return 16'((st[3] << 12) | (st[2] << 8) | (st[1] << 4) | st[0]);
  endfunction

  function automatic bit modelHappy();
    return (mode == 0) && st[0] >= 7 && st[1] >= 7 && st[2] >= 7 && st[3] >= 7;
  endfunction

  function automatic logic [1:0] iconCode(input int which);
    case (which)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [3:0] modelFigure();
    int mn = st[0];
    int which = 0;
    logic [1:0] face, icon;
    if (mode == 2) return 4'b0000;
    if (mode == 1) return 4'b1001;
    for (int k = 1; k < 4; k++) if (st[k] < mn) begin mn = st[k]; which = k; end
    icon = iconCode(which);
    if (mn < 3)            face = 2'b00;
    else if (modelHappy()) face = 2'b01;
    else                   face = 2'b10;
`ifdef PET_ROTATE_EN
    if (face == 2'b01) icon = iconCode(rot);
`endif
    return {face, icon};
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 4; k++) st[k] = 10;
    mode = 0; edge_cnt = 0; rot = 0; fig_exp = 4'b0100;
  endtask

  task automatic modelStep(input bit feed, input bit play, input bit heal, input bit slp);
    bit tick, strobe;
    int dec;
    edge_cnt++;
    tick   = (edge_cnt % 4) == 0;
    strobe = (edge_cnt % 8) == 0;
    dec    = strobe ? 1 : 0;
    fig_exp = modelFigure();
    if (!modelHappy()) rot = 0;
    else if (tick)     rot = (rot + 1) % 4;
    case (mode)
      0: begin
        st[0] = clampStat(st[0] + (heal ? 3 : 0) - dec);
        st[1] = clampStat(st[1] + (feed ? 3 : 0) - dec);
        st[2] = clampStat(st[2] - dec);
        st[3] = clampStat(st[3] + (play ? 3 : 0) - dec);
        if (st[0] == 0) mode = 2;
        else if (slp)   mode = 1;
      end
      1: begin
        st[0] = clampStat(st[0] + (heal ? 3 : 0) - dec);
        st[1] = clampStat(st[1] - dec);
        st[2] = clampStat(st[2] + dec);
        st[3] = clampStat(st[3] - dec);
        if (st[0] == 0)              mode = 2;
        else if (slp || st[2] == 10) mode = 0;
      end
      default: begin
        if (heal) begin st[0] = 3; mode = 0; end
      end
    endcase
  endtask

  // One clock cycle of stimulus; the model advances and all outputs are compared
  task automatic applyStimulus(input bit feed, input bit play, input bit heal, input bit slp, input bit rst_n);
    btn_feed = feed; btn_play = play; btn_heal = heal; btn_sleep = slp; reset = rst_n;
    @(posedge clk);
    #1;
    if (!rst_n) modelReset();
    else        modelStep(feed, play, heal, slp);
    btn_feed = 1'b0; btn_play = 1'b0; btn_heal = 1'b0; btn_sleep = 1'b0; reset = 1'b1;
    checkOutput("model_stats", stats, modelStats());
    checkOutput("model_sleeping", {15'd0, sleeping}, {15'd0, mode == 1});
    checkOutput("model_figure", {12'd0, select_figures}, {12'd0, fig_exp});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; btn_feed = 1'b0; btn_play = 1'b0; btn_heal = 1'b0; btn_sleep = 1'b0;
    modelReset();
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("reset_stats", stats, 16'hAAAA);
    checkOutput("reset_figure", {12'd0, select_figures}, 16'h0004);
    checkOutput("reset_sleeping", {15'd0, sleeping}, 16'h0000);

    // Eight decay strobes with no buttons, plus one cycle for the figure register
    repeat (65) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("decay8_stats", stats, 16'h2222);
    checkOutput("decay8_figure", {12'd0, select_figures}, 16'h0000);

    // Feed lands on the first decay strobe
    applyStimulus(0, 0, 0, 0, 0);
    repeat (7) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("feed_on_strobe", stats, 16'h99A9);

    // Decay until health empties, then critical handling
    for (int i = 0; i < 200 && mode != 2; i++) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("critical_figure", {12'd0, select_figures}, 16'h0000);
    checkOutput("critical_stats", stats, 16'h0010);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("critical_feed_ignored", stats, 16'h0010);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("critical_heal_stats", stats, 16'h0013);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("heal_awake_figure", {12'd0, select_figures}, 16'h0001);

    // Sleep at energy 5 and wake automatically once energy refills
    applyStimulus(0, 0, 0, 0, 0);
    repeat (40) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("pre_sleep_stats", stats, 16'h5555);
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("sleep_entered", {15'd0, sleeping}, 16'h0001);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("sleep_figure", {12'd0, select_figures}, 16'h0009);
    repeat (36) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("auto_wake_sleeping", {15'd0, sleeping}, 16'h0000);
    checkOutput("auto_wake_stats", stats, 16'h0A05);

    // Randomised play with occasional resets
    for (int i = 0; i < 2500; i++) begin
      applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 499) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
